// File: rtl/arx_sequencer.sv
// ARX sequencer: multi-round add/xor/rotate engine driving a 2R1W register file.
// Each round is READ -> EXEC -> WRITE; later rounds chain through rd.
module arx_sequencer #(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 16,
  localparam int AW = $clog2(REG_COUNT),
  localparam int SW = $clog2(REG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [AW-1:0]        cmd_rd,
  input  logic [AW-1:0]        cmd_rs1,
  input  logic [AW-1:0]        cmd_rs2,
  input  logic [SW-1:0]        cmd_shamt,
  input  logic [3:0]           cmd_rounds,
  output logic [AW-1:0]        rf_raddr1,
  output logic [AW-1:0]        rf_raddr2,
  input  logic [REG_WIDTH-1:0] rf_rdata1,
  input  logic [REG_WIDTH-1:0] rf_rdata2,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [REG_WIDTH-1:0] rf_wdata,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_XOR  = 2'd1;
  localparam logic [1:0] OP_ROTL = 2'd2;
  localparam logic [1:0] OP_ARX  = 2'd3;

  logic [1:0]           state;
  logic [1:0]           op_q;
  logic [AW-1:0]        rd_q;
  logic [AW-1:0]        rs1_q;
  logic [AW-1:0]        rs2_q;
  logic [SW-1:0]        sh_q;
  logic [4:0]           cnt_q;
  logic [REG_WIDTH-1:0] a_q;
  logic [REG_WIDTH-1:0] b_q;
  logic [REG_WIDTH-1:0] res_q;

  logic [REG_WIDTH-1:0]   sum;
  logic [REG_WIDTH-1:0]   rot_in;
  logic [2*REG_WIDTH-1:0] rot_dbl;
  logic [REG_WIDTH-1:0]   rot;
  logic [REG_WIDTH-1:0]   alu;

  // Rotate via a doubled word so shamt == 0 needs no special case.
  always_comb begin
    sum     = a_q + b_q;
    rot_in  = (op_q == OP_ARX) ? sum : a_q;
    rot_dbl = {rot_in, rot_in} << sh_q;
    rot     = rot_dbl[2*REG_WIDTH-1:REG_WIDTH];
    alu     = '0;
    unique case (op_q)
      OP_ADD:  alu = sum;
      OP_XOR:  alu = a_q ^ b_q;
      OP_ROTL: alu = rot;
      OP_ARX:  alu = rot ^ b_q;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
            sh_q  <= cmd_shamt;
            cnt_q <= (cmd_rounds == 4'd0) ? 5'd16
                                          : {1'b0, cmd_rounds};
            state <= READ;
          end
        end
        READ: begin
          a_q   <= rf_rdata1;
          b_q   <= rf_rdata2;
          state <= EXEC;
        end
        EXEC: begin
          res_q <= alu;
          state <= WRITE;
        end
        WRITE: begin
          if (cnt_q == 5'd1) begin
            state <= IDLE;
          end else begin
            cnt_q <= cnt_q - 5'd1;
            rs1_q <= rd_q;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = rst_n && (state == IDLE);
  assign busy      = (state != IDLE);
  assign rf_we     = (state == WRITE);
  assign done      = rf_we && (cnt_q == 5'd1);
  assign rf_raddr1 = rs1_q;
  assign rf_raddr2 = rs2_q;
  assign rf_waddr  = rd_q;
  assign rf_wdata  = res_q;

endmodule

// File: doc/arx_sequencer.md
ARX_SEQUENCER -- requirements
Module: arx_sequencer

Interface
REQ-001 The module SHALL have parameter REG_WIDTH, default 32, data word width, identical to the register file's.
REQ-002 The module SHALL have parameter REG_COUNT, default 16, register count; AW = $clog2(REG_COUNT), SW = $clog2(REG_WIDTH).
REQ-003 The module SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port cmd_valid  input  1  command offered.
REQ-006 The module SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-007 The module SHALL have port cmd_op  input  2  00 ADD, 01 XOR, 10 ROTL, 11 ARX.
REQ-008 The module SHALL have ports cmd_rd, cmd_rs1, cmd_rs2  input  AW each  destination and source register indices.
REQ-009 The module SHALL have port cmd_shamt  input  SW  rotate amount.
REQ-010 The module SHALL have port cmd_rounds  input  4  repeat count; 0 means 16.
REQ-011 The module SHALL have ports rf_raddr1, rf_raddr2  output  AW each  register-file read addresses.
REQ-012 The module SHALL have ports rf_rdata1, rf_rdata2  input  REG_WIDTH each  asynchronous register-file read data.
REQ-013 The module SHALL have ports rf_we  output  1, rf_waddr  output  AW, rf_wdata  output  REG_WIDTH  synchronous register-file write port.
REQ-014 The module SHALL have ports busy  output  1 (high outside IDLE) and done  output  1 (one-cycle pulse at command completion).

Function
REQ-015 The FSM SHALL have states IDLE, READ, EXEC, WRITE; cmd_ready SHALL be high only in IDLE.
REQ-016 On acceptance, the module SHALL latch op, rd, rs1, rs2, shamt, and the round count, and move IDLE->READ; cmd_valid outside IDLE SHALL be ignored.
REQ-017 READ: rf_raddr1 = current rs1, rf_raddr2 = rs2; at the edge, rf_rdata1/rf_rdata2 SHALL be captured into operand registers a, b; next state EXEC.
REQ-018 EXEC: result SHALL be registered as ADD a+b mod 2^REG_WIDTH; XOR a^b; ROTL rotl(a, shamt); ARX rotl(a+b mod 2^W, shamt)^b; next state WRITE.
REQ-019 A shamt of 0 SHALL leave the rotate operand unchanged; the carry out of the addition SHALL be discarded.
REQ-020 WRITE: rf_we = 1, rf_waddr = rd, rf_wdata = result for exactly one cycle; rf_we SHALL be 0 in every other state.
REQ-021 After WRITE, with rounds remaining, the round counter SHALL decrement, the current rs1 SHALL become rd, and the next state SHALL be READ, so the next round reads the just-written value.
REQ-022 After the final WRITE, done SHALL pulse for one cycle coincident with that WRITE cycle, and the next state SHALL be IDLE.
REQ-023 Latency: a single-round command accepted at edge 0 SHALL have rf_we/done high in the cycle after edge 2; an N-round command SHALL complete in 3N cycles; cmd_ready SHALL return high in the following cycle.
REQ-024 rd == rs1 or rd == rs2 SHALL be legal; round k+1 SHALL read the value written in round k.
REQ-025 rf_raddr1/rf_raddr2 SHALL hold their last values outside READ; only READ-captured data is used.

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, rf_we 0, done 0, busy 0, cmd_ready 0 while rst_n is low, and all latched fields, operands, result, counter, and read addresses 0.
REQ-027 Reset asserted mid-command SHALL abandon the command with no further rf_we; after release, cmd_ready SHALL be 1 from the first cycle.

Verification
REQ-028 ADD with r1 = 0xFFFFFFFF, r2 = 0x00000002, rd = 3, rounds = 1 -> one rf_we, waddr 3, wdata 0x00000001, done with rf_we, 3 cycles after acceptance.
REQ-029 ROTL with r1 = 0x80000001, shamt = 4, then shamt = 0 -> wdata 0x00000018, then 0x80000001.
REQ-030 ARX with r1 = 0x00000001, r2 = 0x00000001, shamt = 1, rd = 1, rs1 = 1, rounds = 3 -> writes 0x00000005, 0x0000000D, 0x0000001D to r1, done once after 9 cycles.
REQ-031 cmd_valid held high during busy with a second command -> second command not accepted until cmd_ready is high; then executed exactly once.
REQ-032 rst_n pulsed low during EXEC of a 4-round XOR -> rf_we never asserted afterwards, outputs zero, cmd_ready high after release.
REQ-033 rounds = 0 with XOR, r2 = 0x1, rs1 = rd = 5, r5 = 0 -> 16 writes alternating 0x1/0x0, final r5 = 0x0, 48 cycles.
